// File: rtl/target_rx.sv
// DDR receive datapath for the target: deserialises preamble, data bytes, parity, CRC token and CRC value.
// Define TARGET_RX_CRC_CHECK_EN to flag mismatches between the received CRC value and the CRC engine.
module target_rx (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic       i_sclgen_scl_pos_edge,
    input  logic       i_sclgen_scl_neg_edge,
    input  logic       i_sdahnd_tgt_serial_data,
    input  logic       i_ddrccc_rx_en,
    input  logic [2:0] i_ddrccc_rx_mode,
    input  logic [4:0] i_crc_crc_value,
    output logic       o_ddrccc_rx_mode_done,
    output logic       o_ddrccc_pre,
    output logic       o_ddrccc_error,
    output logic       o_regf_wr_en,
    output logic [7:0] o_regf_data,
    output logic       o_crc_en,
    output logic [7:0] o_crc_parallel_data
);

    localparam logic [2:0] ModePre  = 3'b000;
    localparam logic [2:0] ModeByte = 3'b011;
    localparam logic [2:0] ModePar  = 3'b110;
    localparam logic [2:0] ModeTok  = 3'b010;
    localparam logic [2:0] ModeCrc  = 3'b111;

    localparam logic [3:0] CrcToken = 4'b1100;

`ifdef TARGET_RX_CRC_CHECK_EN
    localparam bit CrcCheckEn = 1'b1;
`else
    localparam bit CrcCheckEn = 1'b0;
`endif

    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  mode_q;
    logic        byte_idx_q, byte_idx_d;
    logic [15:0] par_word_q, par_word_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        wr_en_q, wr_en_d;
    logic        crc_en_q, crc_en_d;
    logic        pre_q, pre_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  crc_data_q, crc_data_d;

    logic        sda_edge;
    logic        mode_valid;
    logic        active;
    logic [2:0]  last_idx;
    logic [2:0]  cnt_eff;
    logic        last_bit;
    logic [7:0]  rx_byte;
    logic [1:0]  exp_par;

    always_comb begin
        sda_edge   = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;
        mode_valid = 1'b1;
        last_idx   = 3'd0;
        unique case (i_ddrccc_rx_mode)
            ModePre:  last_idx = 3'd0;
            ModeByte: last_idx = 3'd7;
            ModePar:  last_idx = 3'd1;
            ModeTok:  last_idx = 3'd3;
            ModeCrc:  last_idx = 3'd4;
            default:  mode_valid = 1'b0;
        endcase
        active   = i_ddrccc_rx_en & mode_valid;
        // A mode switch abandons any partially received field.
        cnt_eff  = (i_ddrccc_rx_mode != mode_q) ? 3'd0 : bit_cnt_q;
        last_bit = (cnt_eff == last_idx);
        rx_byte  = {shift_q[6:0], i_sdahnd_tgt_serial_data};
        exp_par  = {^(par_word_q & 16'hAAAA), ~^(par_word_q & 16'h5555)};
    end

    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        par_word_d = par_word_q;
        pre_d      = pre_q;
        data_d     = data_q;
        crc_data_d = crc_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        wr_en_d    = 1'b0;
        crc_en_d   = 1'b0;

        if (!active) begin
            bit_cnt_d = 3'd0;
        end else if (sda_edge) begin
            shift_d = rx_byte;
            if (last_bit) begin
                bit_cnt_d = 3'd0;
                done_d    = 1'b1;
                case (i_ddrccc_rx_mode)
                    ModePre: begin
                        pre_d      = i_sdahnd_tgt_serial_data;
                        byte_idx_d = 1'b0;
                    end
                    ModeByte: begin
                        data_d     = rx_byte;
                        crc_data_d = rx_byte;
                        wr_en_d    = 1'b1;
                        crc_en_d   = 1'b1;
                        if (byte_idx_q) par_word_d[7:0] = rx_byte;
                        else            par_word_d[15:8] = rx_byte;
                        byte_idx_d = ~byte_idx_q;
                    end
                    ModePar: err_d = (rx_byte[1:0] != exp_par);
                    ModeTok: err_d = (rx_byte[3:0] != CrcToken);
                    ModeCrc: err_d = CrcCheckEn && (rx_byte[4:0] != i_crc_crc_value);
                    default: ;
                endcase
            end else begin
                bit_cnt_d = cnt_eff + 3'd1;
            end
        end else if (i_ddrccc_rx_mode != mode_q) begin
            bit_cnt_d = 3'd0;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            shift_q    <= 8'd0;
            bit_cnt_q  <= 3'd0;
            mode_q     <= 3'd0;
            byte_idx_q <= 1'b0;
            par_word_q <= 16'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            crc_en_q   <= 1'b0;
            pre_q      <= 1'b0;
            data_q     <= 8'd0;
            crc_data_q <= 8'd0;
        end else begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            mode_q     <= i_ddrccc_rx_mode;
            byte_idx_q <= byte_idx_d;
            par_word_q <= par_word_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wr_en_q    <= wr_en_d;
            crc_en_q   <= crc_en_d;
            pre_q      <= pre_d;
            data_q     <= data_d;
            crc_data_q <= crc_data_d;
        end
    end

    assign o_ddrccc_rx_mode_done = done_q;
    assign o_ddrccc_error        = err_q;
    assign o_ddrccc_pre          = pre_q;
    assign o_regf_wr_en          = wr_en_q;
    assign o_regf_data           = data_q;
    assign o_crc_en              = crc_en_q;
    assign o_crc_parallel_data   = crc_data_q;

endmodule

// File: tb/tb_target_rx.sv
// Scoreboard bench for target_rx: stimulus pushes expected field results, a monitor checks each done.
module tb_target_rx;

    logic       clk;
    logic       rst_n;
    logic       pos_e;
    logic       neg_e;
    logic       sda;
    logic       rx_en;
    logic [2:0] rx_mode;
    logic [4:0] crc_val;
    logic       done;
    logic       pre;
    logic       err;
    logic       wr_en;
    logic [7:0] rdata;
    logic       crc_en;
    logic [7:0] crc_data;

    target_rx dut (
        .i_sys_clk                (clk),
        .i_sys_rst                (rst_n),
        .i_sclgen_scl_pos_edge    (pos_e),
        .i_sclgen_scl_neg_edge    (neg_e),
        .i_sdahnd_tgt_serial_data (sda),
        .i_ddrccc_rx_en           (rx_en),
        .i_ddrccc_rx_mode         (rx_mode),
        .i_crc_crc_value          (crc_val),
        .o_ddrccc_rx_mode_done    (done),
        .o_ddrccc_pre             (pre),
        .o_ddrccc_error           (err),
        .o_regf_wr_en             (wr_en),
        .o_regf_data              (rdata),
        .o_crc_en                 (crc_en),
        .o_crc_parallel_data      (crc_data)
    );

    typedef struct packed {
        logic       err;
        logic       wr;
        logic [7:0] data;
        logic       pre;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   use_pos = 1'b1;

    localparam logic [2:0] MPre = 3'b000, MByte = 3'b011, MPar = 3'b110;
    localparam logic [2:0] MTok = 3'b010, MCrc = 3'b111, MIdle = 3'b001;

`ifdef TARGET_RX_CRC_CHECK_EN
    localparam logic CrcErrExp = 1'b1;
`else
    localparam logic CrcErrExp = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, req, $time);
    endtask

    task automatic push(input logic e, input logic w, input logic [7:0] d, input logic p);
        exp_t x;
        x.err = e; x.wr = w; x.data = d; x.pre = p;
        exp_q.push_back(x);
    endtask

    task automatic send_bit(input logic b, input bit coincident);
        @(negedge clk);
        sda = b;
        if (coincident) begin
            pos_e = 1'b1; neg_e = 1'b1;
        end else if (use_pos) pos_e = 1'b1;
        else neg_e = 1'b1;
        use_pos = ~use_pos;
        @(negedge clk);
        pos_e = 1'b0; neg_e = 1'b0;
    endtask

    task automatic send_field(input logic [7:0] v, input int n, input int coin_idx);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], i == coin_idx);
    endtask

    task automatic set_mode(input logic [2:0] m);
        @(negedge clk);
        rx_mode = m;
        rx_en   = 1'b1;
    endtask

    // Monitor: every done pops one expectation; any other pulse without done is stray.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 8'd1, 8'd0);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    chk("error", {7'd0, err}, {7'd0, x.err});
                    chk("wr_en", {7'd0, wr_en}, {7'd0, x.wr});
                    chk("crc_en", {7'd0, crc_en}, {7'd0, x.wr});
                    chk("regf_data", rdata, x.data);
                    chk("crc_data", crc_data, x.data);
                    chk("pre", {7'd0, pre}, {7'd0, x.pre});
                end
            end else if ((err | wr_en | crc_en) === 1'b1) begin
                chk("stray_pulse", {5'd0, err, wr_en, crc_en}, 8'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pos_e = 1'b0; neg_e = 1'b0; sda = 1'b0;
        rx_en = 1'b0; rx_mode = MIdle; crc_val = 5'b10110;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {done, pre, err, wr_en, crc_en, 3'd0}, 8'd0);
        chk("rst_data", rdata | crc_data, 8'd0);
        rst_n = 1'b1;

        // Preamble then byte 0xA5, second byte 0x3C, parity 0,1 (good)
        set_mode(MPre);  push(1'b0, 1'b0, 8'h00, 1'b1); send_field(8'h01, 1, -1);
        set_mode(MByte); push(1'b0, 1'b1, 8'hA5, 1'b1); send_field(8'hA5, 8, -1);
        push(1'b0, 1'b1, 8'h3C, 1'b1); send_field(8'h3C, 8, -1);
        set_mode(MPar);  push(1'b0, 1'b0, 8'h3C, 1'b1); send_field(8'h01, 2, -1);

        // Same bytes, parity 1,1 (bad); preamble 0 this time
        set_mode(MPre);  push(1'b0, 1'b0, 8'h3C, 1'b0); send_field(8'h00, 1, -1);
        set_mode(MByte); push(1'b0, 1'b1, 8'hA5, 1'b0); send_field(8'hA5, 8, -1);
        push(1'b0, 1'b1, 8'h3C, 1'b0); send_field(8'h3C, 8, -1);
        set_mode(MPar);  push(1'b1, 1'b0, 8'h3C, 1'b0); send_field(8'h03, 2, -1);

        // CRC token good / bad
        set_mode(MTok); push(1'b0, 1'b0, 8'h3C, 1'b0); send_field(8'h0C, 4, -1);
        push(1'b1, 1'b0, 8'h3C, 1'b0); send_field(8'h08, 4, -1);

        // CRC value good / bad
        set_mode(MCrc); push(1'b0, 1'b0, 8'h3C, 1'b0); send_field(8'h16, 5, -1);
        push(CrcErrExp, 1'b0, 8'h3C, 1'b0); send_field(8'h17, 5, -1);

        // Mode change after one parity bit: token must start from bit 0
        set_mode(MPar); send_field(8'h01, 1, -1);
        set_mode(MTok); push(1'b0, 1'b0, 8'h3C, 1'b0); send_field(8'h0C, 4, -1);

        // Partial byte with a coincident edge, rx_en dropped, edge ignored while disabled
        set_mode(MByte); send_field(8'hF0, 4, 6);
        @(negedge clk); rx_en = 1'b0;
        send_bit(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("hold_data", rdata, 8'h3C);
        rx_en = 1'b1;
        push(1'b0, 1'b1, 8'h96, 1'b0); send_field(8'h96, 8, 4);

        // Idle mode ignores edges
        set_mode(MIdle); send_field(8'hFF, 8, -1);
        chk("idle_hold", rdata, 8'h96);

        // Reset mid-byte
        set_mode(MPre);  push(1'b0, 1'b0, 8'h96, 1'b1); send_field(8'h01, 1, -1);
        set_mode(MByte); send_field(8'hE0, 3, -1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {done, pre, err, wr_en, crc_en, 3'd0}, 8'd0);
        chk("midrst_data", rdata | crc_data, 8'd0);
        @(negedge clk); rst_n = 1'b1;
        push(1'b0, 1'b1, 8'h5A, 1'b0); send_field(8'h5A, 8, -1);

        repeat (5) @(negedge clk);
        chk("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
